// File: rtl/neo_strand_ctrl_p.sv
`default_nettype none
// neo_strand_ctrl_p: double-buffered WS2812-class strand driver (GRB/GRBW, NUM_PIXELS pixels).
// Optional macro NEO_BRIGHTNESS_EN adds a brightness input that scales bytes at snapshot time.
module neo_strand_ctrl_p #(
  parameter int NUM_PIXELS   = 8,
  parameter int COLORS       = 3,
  parameter int T0H          = 18,
  parameter int T1H          = 35,
  parameter int TBIT         = 63,
  parameter int RESET_CYCLES = 2500,
  localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [PW-1:0] pixel_index,
  input  logic [1:0]    color_index,
  input  logic [7:0]    color_level,
  input  logic          load_color,
  input  logic          send_it,
`ifdef NEO_BRIGHTNESS_EN
  input  logic [7:0]    brightness,
`endif
  output logic          neo_data,
  output logic          ready_to_load,
  output logic          ready_to_send,
  output logic          busy,
  output logic          done_send
);

  localparam int NBITS = NUM_PIXELS * COLORS * 8;
  localparam int CMAX  = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int BW    = $clog2(NBITS + 1);

  localparam logic [CW-1:0] C_T0H_M1  = CW'(T0H - 1);
  localparam logic [CW-1:0] C_T1H_M1  = CW'(T1H - 1);
  localparam logic [CW-1:0] C_TBIT_M1 = CW'(TBIT - 1);
  localparam logic [CW-1:0] C_RST_M1  = CW'(RESET_CYCLES - 1);
  localparam logic [BW-1:0] C_LAST    = BW'(NBITS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND_HI = 2'd1;
  localparam logic [1:0] S_SEND_LO = 2'd2;
  localparam logic [1:0] S_LATCH   = 2'd3;

  logic [7:0]       r_load_buf [NUM_PIXELS][COLORS];
  logic [NBITS-1:0] r_shift;
  logic [NBITS-1:0] w_snap;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_bits;
  logic [1:0]       r_state;
  logic             r_neo;
  logic             r_done;
  logic             w_hi_end;

  // Wire order is G, R, B, W while the load buffer is indexed R, G, B, W.
  function automatic int f_slot(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : k);
  endfunction

`ifdef NEO_BRIGHTNESS_EN
  function automatic logic [7:0] f_scale(input logic [7:0] lvl, input logic [7:0] br);
    logic [15:0] w_prod;
    w_prod = 16'(lvl) * (16'(br) + 16'd1);
    return w_prod[15:8];
  endfunction
`endif

  // Out-of-range pixel or color indices simply match no buffer entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PIXELS; p++)
        for (int c = 0; c < COLORS; c++)
          r_load_buf[p][c] <= 8'h00;
    end else if (load_color) begin
      for (int p = 0; p < NUM_PIXELS; p++)
        for (int c = 0; c < COLORS; c++)
          if (pixel_index == PW'(p) && color_index == 2'(c))
            r_load_buf[p][c] <= color_level;
    end
  end

  always_comb begin
    w_snap = '0;
    for (int p = 0; p < NUM_PIXELS; p++) begin
      for (int k = 0; k < COLORS; k++) begin
`ifdef NEO_BRIGHTNESS_EN
        w_snap[NBITS-1-(p*COLORS+k)*8 -: 8] = f_scale(r_load_buf[p][f_slot(k)], brightness);
`else
        w_snap[NBITS-1-(p*COLORS+k)*8 -: 8] = r_load_buf[p][f_slot(k)];
`endif
      end
    end
  end

  assign w_hi_end = (r_cnt == (r_shift[NBITS-1] ? C_T1H_M1 : C_T0H_M1));

  // r_cnt runs across the whole bit period, so SEND_LO ends at TBIT regardless of the high time.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_neo   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (send_it) begin
            r_shift <= w_snap;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_neo   <= 1'b1;
            r_state <= S_SEND_HI;
          end
        end
        S_SEND_HI: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_hi_end) begin
            r_neo   <= 1'b0;
            r_state <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (r_cnt == C_TBIT_M1) begin
            r_cnt <= '0;
            if (r_bits == C_LAST) begin
              r_state <= S_LATCH;
            end else begin
              r_shift <= {r_shift[NBITS-2:0], 1'b0};
              r_bits  <= r_bits + BW'(1);
              r_neo   <= 1'b1;
              r_state <= S_SEND_HI;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_LATCH: begin
          if (r_cnt == C_RST_M1) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign neo_data      = r_neo;
  assign ready_to_load = 1'b1;
  assign ready_to_send = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign done_send     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_neo_strand_ctrl_p.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for neo_strand_ctrl_p: scoreboard of expected bits checked against decoded neo_data,
// plus two auxiliary instances (GRBW and a non-power-of-two strand) captured bit by bit.
module tb_neo_strand_ctrl_p;
  localparam int NP = 8, NC = 3, T0 = 18, T1 = 35, TB = 63, RC = 2500, ARC = 100;
  localparam int NB = NP * NC * 8;
  localparam int FRAME = NB * TB + RC;

  logic clock = 1'b0, reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] pixel_index = '0;
  logic [1:0] color_index = '0;
  logic [7:0] color_level = '0;
  logic       load_m = 1'b0, send_m = 1'b0;
  logic [1:0] a_load = '0, a_send = '0;
  logic       neo_data, rtl, rts, busy, done_send;
  logic [1:0] a_neo, a_done, a_rtl, a_rts, a_busy;

  neo_strand_ctrl_p #(.NUM_PIXELS(NP), .COLORS(NC), .T0H(T0), .T1H(T1), .TBIT(TB), .RESET_CYCLES(RC)) u_dut (
    .clock(clock), .reset_n(reset_n), .pixel_index(pixel_index), .color_index(color_index),
    .color_level(color_level), .load_color(load_m), .send_it(send_m),
`ifdef NEO_BRIGHTNESS_EN
    .brightness(8'hFF),
`endif
    .neo_data(neo_data), .ready_to_load(rtl), .ready_to_send(rts), .busy(busy), .done_send(done_send));

  neo_strand_ctrl_p #(.NUM_PIXELS(8), .COLORS(4), .T0H(T0), .T1H(T1), .TBIT(TB), .RESET_CYCLES(ARC)) u_grbw (
    .clock(clock), .reset_n(reset_n), .pixel_index(pixel_index), .color_index(color_index),
    .color_level(color_level), .load_color(a_load[0]), .send_it(a_send[0]),
`ifdef NEO_BRIGHTNESS_EN
    .brightness(8'hFF),
`endif
    .neo_data(a_neo[0]), .ready_to_load(a_rtl[0]), .ready_to_send(a_rts[0]), .busy(a_busy[0]), .done_send(a_done[0]));

  neo_strand_ctrl_p #(.NUM_PIXELS(5), .COLORS(3), .T0H(T0), .T1H(T1), .TBIT(TB), .RESET_CYCLES(ARC)) u_odd (
    .clock(clock), .reset_n(reset_n), .pixel_index(pixel_index), .color_index(color_index),
    .color_level(color_level), .load_color(a_load[1]), .send_it(a_send[1]),
`ifdef NEO_BRIGHTNESS_EN
    .brightness(8'hFF),
`endif
    .neo_data(a_neo[1]), .ready_to_load(a_rtl[1]), .ready_to_send(a_rts[1]), .busy(a_busy[1]), .done_send(a_done[1]));

  int n_tests = 0, n_fail = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference load buffer, indexed [pixel][R,G,B,W]
  logic [7:0] mbuf [NP][4];
  bit exp_q[$];

  task automatic push_frame();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < NC; k++) begin
        int c;
        c = (k == 0) ? 1 : ((k == 1) ? 0 : k);
        for (int b = 7; b >= 0; b--) exp_q.push_back(mbuf[p][c][b]);
      end
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < 4; c++) mbuf[p][c] = 8'h00;
  endtask

  // Monitors sample on the falling edge; the driver acts 1 ns later.
  int  cyc = 0, hi = 0, since = 0, mon_bit = 0, done_cnt = 0;
  bit  prev = 0, prev_done = 0;
  int  rise_q[$], done_q[$];
  int  a_hi[2], a_n[2], a_dcnt[2];
  bit  a_prev[2];
  logic [255:0] a_bits[2];

  initial begin
    for (int k = 0; k < 2; k++) begin a_hi[k] = 0; a_n[k] = 0; a_dcnt[k] = 0; a_prev[k] = 0; a_bits[k] = '0; end
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        prev = 0; hi = 0; since = 0; mon_bit = 0; prev_done = 0;
      end else begin
        since++;
        if (neo_data && !prev) begin
          if (mon_bit != 0) check($sformatf("bit%0d_period", mon_bit), since, TB);
          else rise_q.push_back(cyc);
          since = 0;
        end
        if (neo_data) hi++;
        if (!neo_data && prev) begin
          check("bit_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            bit e;
            e = exp_q.pop_front();
            check($sformatf("bit%0d_high", mon_bit), hi, e ? T1 : T0);
          end
          hi = 0;
          mon_bit++;
          if (mon_bit == NB) mon_bit = 0;
        end
        if (done_send) begin
          check("done_one_cycle", prev_done, 0);
          check("rts_at_done", rts, 1);
          if (!prev_done) begin done_cnt++; done_q.push_back(cyc); end
        end
        prev = neo_data;
        prev_done = done_send;
        for (int k = 0; k < 2; k++) begin
          if (a_neo[k]) a_hi[k]++;
          if (!a_neo[k] && a_prev[k]) begin
            check($sformatf("aux%0d_high", k), (a_hi[k] == T0) || (a_hi[k] == T1), 1);
            if (a_n[k] < 256) a_bits[k][a_n[k]] = (a_hi[k] > (T0 + T1) / 2);
            a_n[k]++;
            a_hi[k] = 0;
          end
          if (a_done[k]) a_dcnt[k]++;
          a_prev[k] = a_neo[k];
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic load_main(input int p, input int c, input int lvl);
    pixel_index = 3'(p); color_index = 2'(c); color_level = 8'(lvl); load_m = 1'b1;
    tick();
    load_m = 1'b0;
  endtask

  task automatic load_aux(input int k, input int p, input int c, input int lvl);
    pixel_index = 3'(p); color_index = 2'(c); color_level = 8'(lvl); a_load[k] = 1'b1;
    tick();
    a_load = '0;
  endtask

  task automatic wait_done(input string nm, input int start, input int budget);
    int n = 0;
    while (done_cnt == start && n < budget) begin tick(); n++; end
    check(nm, done_cnt, start + 1);
  endtask

  task automatic wait_bit(input string nm, input int idx);
    int n = 0;
    while (!(mon_bit == idx && neo_data) && n < idx * TB + 500) begin tick(); n++; end
    check(nm, mon_bit, idx);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    check("async_reset_neo", neo_data, 0);
    exp_q.delete();
    clear_model();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_rts", rts, 1);
    check("post_reset_busy", busy, 0);
  endtask

  function automatic logic [7:0] aux_byte(input int k, input int start);
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) b = {b[6:0], a_bits[k][start+i]};
    return b;
  endfunction

  typedef struct { int pix; int col; int lvl; bit take; } load_t;
  load_t vec [8];

  initial begin
    int d0;
    vec[0] = '{0, 0, 8'hFF, 1'b1};  // pixel 0 R
    vec[1] = '{0, 1, 8'h00, 1'b1};  // pixel 0 G
    vec[2] = '{0, 2, 8'h80, 1'b1};  // pixel 0 B
    vec[3] = '{3, 3, 8'hFF, 1'b0};  // W on a GRB strand
    vec[4] = '{2, 1, 8'h12, 1'b1};
    vec[5] = '{2, 1, 8'h3C, 1'b1};  // overwrites previous entry
    vec[6] = '{7, 2, 8'hAA, 1'b1};
    vec[7] = '{5, 0, 8'hC3, 1'b1};
    clear_model();

    repeat (3) @(posedge clock);
    tick();
    reset_n = 1'b1;
    tick();
    check("reset_neo", neo_data, 0);
    check("reset_rts", rts, 1);
    check("reset_rtl", rtl, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done_send, 0);

    load_aux(0, 1, 3, 8'hA5);
    load_aux(0, 0, 1, 8'h81);
    load_aux(1, 5, 0, 8'hFF);
    load_aux(1, 7, 1, 8'hFF);
    load_aux(1, 2, 3, 8'hFF);
    load_aux(1, 4, 2, 8'h3C);

    // Frame A: zeroed buffer; the table is loaded while it is on the wire.
    send_m = 1'b1; a_send = 2'b11;
    push_frame();
    tick();
    send_m = 1'b0; a_send = 2'b00;
    check("first_rise_latency", neo_data, 1);
    check("sending_busy", busy, 1);
    check("sending_rts", rts, 0);
    for (int i = 0; i < 8; i++) begin
      load_main(vec[i].pix, vec[i].col, vec[i].lvl);
      if (vec[i].take) mbuf[vec[i].pix][vec[i].col] = 8'(vec[i].lvl);
    end
    check("rtl_mid_frame", rtl, 1);
    send_m = 1'b1; tick(); send_m = 1'b0;
    check("mid_send_ignored_busy", busy, 1);
    wait_done("frameA_done", 0, FRAME + 200);
    check("frameA_all_bits", exp_q.size(), 0);

    d0 = 0;
    while (a_dcnt[0] == 0 && d0 < 3000) begin tick(); d0++; end
    check("grbw_done", a_dcnt[0], 1);
    check("grbw_bits", a_n[0], 256);
    check("grbw_p1_w", aux_byte(0, 56), 8'hA5);
    check("grbw_p0_g", aux_byte(0, 0), 8'h81);
    check("grbw_p0_w", aux_byte(0, 24), 8'h00);
    check("odd_done", a_dcnt[1], 1);
    check("odd_bits", a_n[1], 120);
    check("odd_p4_b", aux_byte(1, 112), 8'h3C);
    check("odd_rest_zero", $countones(a_bits[1][111:0]), 0);

    // Frame B carries the table; pixel 7 B changes mid-frame and must only show up in frame C.
    send_m = 1'b1;
    push_frame();
    tick();
    send_m = 1'b0;
    load_main(7, 2, 8'h55);
    mbuf[7][2] = 8'h55;
    load_main(1, 3, 8'h77);
    send_m = 1'b1; tick();
    check("mid_send_busy_B", busy, 1);
    wait_done("frameB_done", 1, FRAME + 200);
    push_frame();
    tick();
    send_m = 1'b0;
    check("b2b_accept_busy", busy, 1);
    if (rise_q.size() >= 3 && done_q.size() >= 2) begin
      check("frameB_length", done_q[1] - rise_q[1], FRAME);
      check("b2b_rise_gap", rise_q[2] - rise_q[1], FRAME + 1);
    end else begin
      check("rise_done_records", rise_q.size() * 10 + done_q.size(), 32);
    end
    wait_done("frameC_done", 2, FRAME + 200);
    check("frameC_all_bits", exp_q.size(), 0);

    // Frame D: reset during bit 40, then frame E must send a cleared buffer.
    send_m = 1'b1; push_frame(); tick(); send_m = 1'b0;
    wait_bit("reach_bit40", 40);
    d0 = done_cnt;
    reset_pulse();
    repeat (200) tick();
    check("no_done_after_reset", done_cnt, d0);
    send_m = 1'b1; push_frame(); tick(); send_m = 1'b0;
    wait_bit("reach_bit48", 48);
    reset_pulse();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/neo_strand_ctrl_p.md
Name: neo_strand_ctrl_p

Overview:
- Parametrised successor to the NeoPixel strand controller; drives one WS2812-class strand of NUM_PIXELS pixels, GRB (COLORS=3) or GRBW (COLORS=4).
- Double-buffered: color loads go to a load buffer and are accepted at any time, including mid-send.
- send_it snapshots the load buffer into a shift buffer, then serialises it on neo_data, followed by the latch/reset low period.
- Sits between the pattern-generation FSM and the strand pin.

Parameters:
- NUM_PIXELS, 8, pixels in strand (1..256).
- COLORS, 3, color bytes per pixel (3=GRB, 4=GRBW).
- T0H, 18, clocks high for a 0 bit.
- T1H, 35, clocks high for a 1 bit.
- TBIT, 63, clocks per bit period (must satisfy T1H < TBIT and T0H < T1H).
- RESET_CYCLES, 2500, clocks low after frame (50 us at 50 MHz).

Ports:
- clock  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- pixel_index  in  $clog2(NUM_PIXELS) (min 1)  pixel to load.
- color_index  in  2  0=R, 1=G, 2=B, 3=W.
- color_level  in  8  intensity byte.
- load_color  in  1  write color_level into load buffer this cycle.
- send_it  in  1  request frame transmission.
- neo_data  out  1  serial strand data.
- ready_to_load  out  1  constant 1 out of reset; loads always accepted.
- ready_to_send  out  1  high only in IDLE.
- busy  out  1  high in SEND_HI, SEND_LO, LATCH.
- done_send  out  1  one-cycle pulse on LATCH->IDLE.

Behaviour:
- Reset (async, reset_n=0): both buffers zeroed; state IDLE; neo_data=0, ready_to_send=1, ready_to_load=1, busy=0, done_send=0. Reset mid-frame forces neo_data=0 immediately.
- Load rules:
  - On a clock edge with load_color=1, load_buf[pixel_index][color_index] <= color_level, in any state.
  - Ignored when pixel_index >= NUM_PIXELS.
  - Ignored when color_index=3 and COLORS=3.
  - Last write to the same byte wins.
- Send acceptance: send_it sampled only in IDLE; ignored otherwise (no queuing).
  - On acceptance, shift_buf <= load_buf. A load_color in the same cycle updates load_buf only and appears in the next frame.
- Bit order: pixel 0 first; per pixel G, R, B, then W if COLORS=4; each byte MSB first. Total NUM_PIXELS*COLORS*8 bits.
- FSM:
  - IDLE -> SEND_HI on accepted send_it. neo_data=1 from the following cycle.
  - SEND_HI: neo_data=1 for T0H or T1H cycles per current bit -> SEND_LO.
  - SEND_LO: neo_data=0 for TBIT minus high time. At the end, next bit -> SEND_HI, or last bit -> LATCH.
  - LATCH: neo_data=0 for RESET_CYCLES -> IDLE with done_send=1 for exactly one cycle.
- Latency: accepted send_it edge N -> neo_data rises at edge N+1. Frame length = bits*TBIT + RESET_CYCLES clocks. done_send is high the cycle ready_to_send returns to 1.
- Counters: cycle counter width $clog2(max(TBIT,RESET_CYCLES)+1); bit counter width $clog2(NUM_PIXELS*COLORS*8+1). No wrap-around inside a frame.
- Back-to-back: send_it held high re-accepts on the first IDLE cycle. The inter-frame gap is therefore exactly RESET_CYCLES low plus 1 IDLE cycle.

Optional Feature:
- Macro NEO_BRIGHTNESS_EN.
- When defined:
  - Extra input brightness [7:0].
  - Each byte is scaled at snapshot time: out = (level*(brightness+1))>>8, 16-bit intermediate.
  - brightness=255 is passthrough; brightness=0 maps 255->0.
  - brightness is sampled only on send_it acceptance.
- When undefined: port absent, bytes sent unscaled.

Test Plan:
- Reset/idle: reset_n=0 for 3 clocks, then 1 -> neo_data=0, ready_to_send=1, busy=0; send of the zeroed buffer gives 192 bits (NUM_PIXELS=8, COLORS=3), each high for exactly 18 clocks.
- Single pixel: load pixel 0 R=0xFF, G=0x00, B=0x80, then send_it -> first 8 bits 0 (G), next 8 all 1 with 35-clock highs (R), then 1000_0000 (B); every bit period 63 clocks; done_send pulses at 192*63+2500 clocks after neo_data rise.
- Mid-send load: during a frame, load pixel 7 B=0x55 -> current frame still sends old pixel 7 B; the next send_it sends 0x55; send_it asserted mid-frame is ignored (busy stays 1, no extra frame).
- Bounds: pixel_index=8 with NUM_PIXELS=8, and color_index=3 with COLORS=3 -> buffer unchanged; sent frame identical to the previous one.
- GRBW: COLORS=4, pixel 1 W=0xA5 -> 256 bits; bits 56..63 = 1010_0101.
- Reset mid-frame: deassert reset_n during bit 40 -> neo_data=0 asynchronously; after release, state IDLE, buffers zero, no done_send pulse.
